micro_op_queue: RTL
===================

# micro_op_queue

Ordered buffer between the x86 instruction expander and the decode stage. It accepts up to two micro-ops per cycle from the expander and presents the oldest one as the `deq_*_head` bundle that decode consumes. The queue absorbs decode stalls and is cleared on pipeline flush. When empty, the head bundle reads as an all-zero NOP.

## Interface
- `DEPTH`, default 8: entry count; power of two, ≥ 4.
- `clk` in 1: clock; all state updates on its rising edge.
- `rst` in 1: reset; synchronous, active-high.
- `flush` in 1: discard all entries (branch/jump redirect).
- `enq_num` in 2: number of micro-ops offered this cycle; 0, 1 or 2 (3 is illegal).
- `enq_opcode[1:0]` in `MICRO_W` each: micro-op opcodes; slot 0 is older.
- `enq_reg_addr_d[1:0]`, `enq_reg_addr_s[1:0]`, `enq_reg_addr_t[1:0]` in `REG_ADDR_W` each: register addresses.
- `enq_immediate[1:0]` in `IMM_W` each: immediates.
- `enq_bit_mode[1:0]` in `BIT_MODE_W` each: operand size.
- `enq_pc[1:0]` in `ADDR_W` each: PC of the parent x86 instruction.
- `enq_ready` out 1: at least 2 free entries.
- `deq_en` in 1: decode consumes the head this cycle; decode drives this as `~stall`.
- `deq_valid` out 1: head bundle holds a real entry.
- `deq_opcode_head`, `deq_reg_addr_d_head`, `deq_reg_addr_s_head`, `deq_reg_addr_t_head`, `deq_immediate_head`, `deq_bit_mode_head`, `deq_pc_head` out, same widths as the `enq_*` fields: oldest entry.
- `count` out log2(DEPTH)+1: occupied entries.

## Operation
- Storage is a circular buffer with read pointer `rp`, write pointer `wp` (log2(DEPTH) bits each, wrap modulo DEPTH) and `count`.
- Enqueue fires when `enq_ready && enq_num != 0`.
  - Slot 0 is written at `wp`. Slot 1, when `enq_num == 2`, is written at `wp+1`.
  - `wp` advances by `enq_num`.
  - If `enq_ready == 0`, nothing is written. The producer holds its inputs; it is never partially accepted.
- Dequeue fires when `deq_en && deq_valid`. `rp` advances by 1. `deq_en` while empty is a no-op.
- On a simultaneous enqueue and dequeue: `count_next = count + enq_num - 1`.
- `enq_ready = (DEPTH - count) >= 2`, computed from registered `count` only. A same-cycle dequeue does not raise `enq_ready`. This is conservative and leaves no combinational path from `deq_en` to `enq_ready`.
- `deq_valid = (count != 0)`.
- Head fields are entry[`rp`] when `deq_valid`, otherwise all zeros (`MICRO_NOP`, register 0, imm 0, pc 0).
- `enq_num == 3` is treated as 0. A simulation-only assertion flags it.
- Priority order: `rst` > `flush` > enqueue/dequeue.
  - `flush` sets `rp = wp = count = 0` and drops any same-cycle enqueue and dequeue.
  - Entry storage contents are don't-care after a flush; they are masked by `deq_valid`.

## Timing
- Reset (and flush) values: `count = 0`, `deq_valid = 0`, `enq_ready = 1`, all head fields 0, `rp = wp = 0`.
- Enqueue-to-head latency is 1 cycle. An entry written at edge N is visible on the head outputs after edge N (with the bypass below disabled).
- Head outputs are combinational from registered pointers and storage only. Decode registers them in the same cycle.
- Throughput: 2 in / 1 out per cycle. A continuous two-wide producer fills the queue until `enq_ready` drops at `count >= DEPTH-1`.
- Full boundary: at `count == DEPTH-1` or `DEPTH`, `enq_ready = 0` even if `deq_en = 1`.
- Wrap-around: a two-entry enqueue with `wp == DEPTH-1` writes entries DEPTH-1 and 0.
- `rst` or `flush` asserted mid-stream takes effect at that edge. The following cycle shows an empty queue with a NOP head.

## Configuration
- `MICRO_QUEUE_BYPASS_EN` defined:
  - When `count == 0` and `enq_num != 0` (and no `flush`), the head outputs show `enq_*[0]` combinationally and `deq_valid = 1`.
  - If `deq_en` is also 1, slot 0 is consumed without being stored. Only slot 1, if present, is written, and `wp` advances by `enq_num - 1`.
  - This gives 0-cycle latency when the queue is empty.
- `MICRO_QUEUE_BYPASS_EN` undefined: no bypass; latency is exactly 1 cycle as in Timing.

## Test plan
- Reset: hold `rst` for 2 cycles with `enq_num = 2` -> `count = 0`, `deq_valid = 0`, `deq_opcode_head = 0`, `enq_ready = 1` throughout.
- Order and latency: enqueue ADDI (pc 0x100), then ADD+SB (pc 0x104) with `deq_en = 1` -> head sequence ADDI, ADD, SB on consecutive cycles starting 1 cycle after the first enqueue; then NOP with `deq_valid = 0`.
- Fill and stall: DEPTH = 8, `deq_en = 0`, `enq_num = 2` every cycle -> `count` goes 2, 4, 6; `enq_ready` drops at `count = 8`. Count stays 8 for further offers and no entry is overwritten. Draining yields entries in order.
- Wrap-around: advance pointers to `wp = 7`, enqueue LD+LEA -> LD is read from entry 7 and LEA from entry 0, in order; `count` is correct.
- Flush collision: with `count = 5`, assert `flush` together with `enq_num = 2` and `deq_en = 1` -> the next cycle shows `count = 0`, NOP head and `enq_ready = 1`.
- Bypass (`MICRO_QUEUE_BYPASS_EN`): empty queue, `enq_num = 1` MOVI, `deq_en = 1` -> the head shows MOVI in the same cycle and `count` stays 0. Without the macro, the head shows MOVI one cycle later and `count = 1`.

Source files
------------

// File: rtl/micro_op_queue.sv
// micro_op_queue: ordered micro-op buffer between the x86 expander and decode.
//
// Accepts up to two micro-ops per cycle (slot 0 older) and presents the oldest
// entry on the deq_*_head bundle. The head reads as an all-zero NOP when empty.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   flush             discard all entries; wins over enqueue/dequeue
//   enq_num           micro-ops offered this cycle (0..2, 3 treated as 0)
//   enq_*[1:0]        offered micro-op fields, slot 0 older
//   enq_ready         at least two free entries (from registered count only)
//   deq_en            decode consumes the head this cycle
//   deq_valid         head bundle holds a real entry
//   deq_*_head        oldest entry fields
//   count             occupied entries
//
// Optional feature macro: MICRO_QUEUE_BYPASS_EN
//   When defined, an empty queue forwards enq_*[0] to the head combinationally;
//   if decode consumes it in the same cycle it is never stored.
module micro_op_queue #(
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned MICRO_W    = 8,
    parameter int unsigned REG_ADDR_W = 4,
    parameter int unsigned IMM_W      = 32,
    parameter int unsigned BIT_MODE_W = 2,
    parameter int unsigned ADDR_W     = 32
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             flush,
    input  logic [1:0]                       enq_num,
    input  logic [1:0][MICRO_W-1:0]          enq_opcode,
    input  logic [1:0][REG_ADDR_W-1:0]       enq_reg_addr_d,
    input  logic [1:0][REG_ADDR_W-1:0]       enq_reg_addr_s,
    input  logic [1:0][REG_ADDR_W-1:0]       enq_reg_addr_t,
    input  logic [1:0][IMM_W-1:0]            enq_immediate,
    input  logic [1:0][BIT_MODE_W-1:0]       enq_bit_mode,
    input  logic [1:0][ADDR_W-1:0]           enq_pc,
    output logic                             enq_ready,
    input  logic                             deq_en,
    output logic                             deq_valid,
    output logic [MICRO_W-1:0]               deq_opcode_head,
    output logic [REG_ADDR_W-1:0]            deq_reg_addr_d_head,
    output logic [REG_ADDR_W-1:0]            deq_reg_addr_s_head,
    output logic [REG_ADDR_W-1:0]            deq_reg_addr_t_head,
    output logic [IMM_W-1:0]                 deq_immediate_head,
    output logic [BIT_MODE_W-1:0]            deq_bit_mode_head,
    output logic [ADDR_W-1:0]                deq_pc_head,
    output logic [$clog2(DEPTH):0]           count
);

    localparam int unsigned PTR_W   = $clog2(DEPTH);
    localparam int unsigned CNT_W   = PTR_W + 1;
    localparam int unsigned ENTRY_W = MICRO_W + 3 * REG_ADDR_W + IMM_W + BIT_MODE_W + ADDR_W;

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [ENTRY_W-1:0] slot [2];
    logic [ENTRY_W-1:0] head;

    logic [PTR_W-1:0] rp, wp;
    logic [1:0]       num;
    logic [1:0]       wr_num;
    logic             bypass;
    logic             skip0;
    logic             enq_fire;
    logic             deq_fire;

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            slot[i] = {enq_opcode[i], enq_reg_addr_d[i], enq_reg_addr_s[i], enq_reg_addr_t[i],
                       enq_immediate[i], enq_bit_mode[i], enq_pc[i]};
        end
    end

    // Illegal count 3 is ignored rather than partially accepted.
    assign num = (enq_num == 2'd3) ? 2'd0 : enq_num;

`ifdef MICRO_QUEUE_BYPASS_EN
    assign bypass = (count == '0) && (num != 2'd0) && !flush && !rst;
`else
    assign bypass = 1'b0;
`endif

    // Conservative: a same-cycle dequeue never raises enq_ready.
    assign enq_ready = (count <= CNT_W'(DEPTH - 2));
    assign enq_fire  = enq_ready && (num != 2'd0);
    assign deq_fire  = deq_en && (count != '0);
    // Slot 0 goes straight to decode when bypassed and consumed.
    assign skip0     = bypass && deq_en;
    assign wr_num    = enq_fire ? (num - {1'b0, skip0}) : 2'd0;

    // Storage is not reset; stale entries are masked by count.
    always_ff @(posedge clk) begin
        if (!rst && !flush) begin
            if (wr_num != 2'd0) begin
                mem[wp] <= skip0 ? slot[1] : slot[0];
            end
            if (wr_num == 2'd2) begin
                mem[wp + PTR_W'(1)] <= slot[1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rp    <= '0;
            wp    <= '0;
            count <= '0;
        end else begin
            rp    <= rp + PTR_W'(deq_fire);
            wp    <= wp + PTR_W'(wr_num);
            count <= count + CNT_W'(wr_num) - CNT_W'(deq_fire);
        end
    end

    always_comb begin
        head = '0;
        if (bypass) begin
            head = slot[0];
        end else if (count != '0) begin
            head = mem[rp];
        end
    end

    assign deq_valid = (count != '0) || bypass;
    assign {deq_opcode_head, deq_reg_addr_d_head, deq_reg_addr_s_head, deq_reg_addr_t_head,
            deq_immediate_head, deq_bit_mode_head, deq_pc_head} = head;

    illegal_enq_num: assert property (@(posedge clk) disable iff (rst) enq_num != 2'd3);

endmodule
